pipelined_adder: RTL and testbench

//   Parametrised WIDTH-bit adder/subtractor. Carry chain split into STAGES registered segments.

---
 rtl/pipelined_adder_pkg.sv | 19 +
 rtl/adder_segment.sv | 18 +
 rtl/pipelined_adder.sv | 144 ++++++++++++++
 tb/tb_pipelined_adder.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared types and constants for the pipelined adder/subtractor.
// Stage control record, flag bit positions and the WIDTH/STAGES consistency check.
package pipelined_adder_pkg;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_OVF  = 1;
  localparam int NUM_FLAGS = 2;

  // Per-stage control: valid bit plus the carry handed to the next segment.
  typedef struct packed {
    logic vld;
    logic carry;
  } stage_ctl_t;

  function automatic bit stages_fit(input int width, input int stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit ripple segment of the pipelined adder.
// Also reports the carry into its MSB so the top level can derive signed overflow.
module adder_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
  // Sum bit = a ^ b ^ carry_in, so the MSB carry-in falls out of the result.
  assign cmsb = sum[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder/subtractor with the carry chain split over STAGES registered segments.
// Define PIPELINED_ADDER_FLAGS_EN to add registered zero/ovf result flags.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_ADDER_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (!stages_fit(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a nonzero multiple of STAGES");
  end

  stage_ctl_t       ctl_p  [STAGES];
  logic [WIDTH-1:0] sum_p  [STAGES];
  logic [WIDTH-1:0] a_p    [STAGES];
  logic [WIDTH-1:0] eb_p   [STAGES];

  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] vld_in;
  logic [STAGES-1:0] carry_nx;
  logic [STAGES-1:0] cmsb_nx;
  logic [WIDTH-1:0]  sum_nx [STAGES];
  logic [WIDTH-1:0]  a_nx   [STAGES];
  logic [WIDTH-1:0]  eb_nx  [STAGES];

  // A stage may load when empty or when its successor is loading this cycle.
  always_comb begin : ready_chain
    logic r;
    r           = out_ready;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r      = !ctl_p[k].vld || r;
      rdy[k] = r;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] merged;
    logic [SEG-1:0]   seg_sum;
    logic             c_in;

    if (k == 0) begin : g_entry
      assign vld_in[k] = in_valid;
      assign a_nx[k]   = a;
      assign eb_nx[k]  = sub ? ~b : b;
      assign c_in      = cin ^ sub;
      assign sum_in    = '0;
    end else begin : g_chain
      assign vld_in[k] = ctl_p[k-1].vld;
      assign a_nx[k]   = a_p[k-1];
      assign eb_nx[k]  = eb_p[k-1];
      assign c_in      = ctl_p[k-1].carry;
      assign sum_in    = sum_p[k-1];
    end

    adder_segment #(.SEG(SEG)) u_seg (
      .a    (a_nx[k][k*SEG +: SEG]),
      .b    (eb_nx[k][k*SEG +: SEG]),
      .cin  (c_in),
      .sum  (seg_sum),
      .cout (carry_nx[k]),
      .cmsb (cmsb_nx[k])
    );

    always_comb begin
      merged                = sum_in;
      merged[k*SEG +: SEG]  = seg_sum;
    end
    assign sum_nx[k] = merged;
  end

  // ---- stage registers p0 .. p(STAGES-1) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_p[k] <= '0;
        sum_p[k] <= '0;
        a_p[k]   <= '0;
        eb_p[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          ctl_p[k].vld <= vld_in[k];
          if (vld_in[k]) begin
            ctl_p[k].carry <= carry_nx[k];
            sum_p[k]       <= sum_nx[k];
            a_p[k]         <= a_nx[k];
            eb_p[k]        <= eb_nx[k];
          end
        end
      end
    end
  end

  // The last stage's operand copies have no consumer.
  logic unused_tail;
  assign unused_tail = ^{a_p[LAST], eb_p[LAST], cmsb_nx};

`ifdef PIPELINED_ADDER_FLAGS_EN
  logic [NUM_FLAGS-1:0] flags_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_p <= '0;
    end else if (rdy[LAST] && vld_in[LAST]) begin
      flags_p[FLAG_ZERO] <= (sum_nx[LAST] == '0);
      flags_p[FLAG_OVF]  <= cmsb_nx[LAST] ^ carry_nx[LAST];
    end
  end

  assign zero = flags_p[FLAG_ZERO];
  assign ovf  = flags_p[FLAG_OVF];
`endif

  assign in_ready  = rdy[0];
  assign out_valid = ctl_p[LAST].vld;
  assign sum       = sum_p[LAST];
  assign cout      = ctl_p[LAST].carry;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed 16-bit/4-stage cases plus
// randomized handshaking on 32-bit builds with 1, 2 and 8 stages, scoreboard-checked.
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;
`ifdef PIPELINED_ADDER_FLAGS_EN
  logic         zero, ovf;
`endif

  logic        r_in_valid [3], r_in_ready [3], r_cin [3], r_sub [3];
  logic        r_out_valid[3], r_out_ready[3], r_cout[3];
  logic [31:0] r_a[3], r_b[3], r_sum[3];
`ifdef PIPELINED_ADDER_FLAGS_EN
  logic        r_zero[3], r_ovf[3];
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        z;
    logic        o;
  } res_t;

  res_t q16[$];

  pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef PIPELINED_ADDER_FLAGS_EN
    , .zero(zero), .ovf(ovf)
`endif
  );

  for (genvar i = 0; i < 3; i++) begin : g_rnd
    localparam int RS = (i == 0) ? 1 : ((i == 1) ? 2 : 8);
    pipelined_adder #(.WIDTH(32), .STAGES(RS)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid[i]), .in_ready(r_in_ready[i]),
      .a(r_a[i]), .b(r_b[i]), .cin(r_cin[i]), .sub(r_sub[i]),
      .out_valid(r_out_valid[i]), .out_ready(r_out_ready[i]), .sum(r_sum[i]), .cout(r_cout[i])
`ifdef PIPELINED_ADDER_FLAGS_EN
      , .zero(r_zero[i]), .ovf(r_ovf[i])
`endif
    );
  end

  // Arithmetic reference: true integer add/subtract, then reduce to w bits.
  function automatic res_t ref_model(input int w, input logic [31:0] x, input logic [31:0] y,
                                     input logic ci, input logic sb);
    res_t r;
    longint unsigned mask, ux, uy, t, half;
    longint sx, sy, st;
    mask = (64'd1 << w) - 64'd1;
    half = 64'd1 << (w - 1);
    ux = {32'd0, x} & mask;
    uy = {32'd0, y} & mask;
    sx = (ux >= half) ? longint'(ux) - longint'(64'd1 << w) : longint'(ux);
    sy = (uy >= half) ? longint'(uy) - longint'(64'd1 << w) : longint'(uy);
    if (!sb) begin
      t   = ux + uy + 64'(ci);
      r.c = t[w];
      st  = sx + sy + longint'(ci);
    end else begin
      t   = ux - uy - 64'(ci);
      r.c = (ux >= uy + 64'(ci));
      st  = sx - sy - longint'(ci);
    end
    r.s = 32'(t & mask);
    r.z = (r.s == 32'd0);
    r.o = (st > longint'(half) - 1) || (st < -longint'(half));
    return r;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // One clock of the 16-bit DUT: sample handshakes mid-cycle, keep the scoreboard.
  task automatic step16(output bit acc, output bit emit, output res_t exp_r, output res_t got_r);
    @(negedge clk);
    #1;
    acc     = in_valid && in_ready;
    emit    = out_valid && out_ready;
    exp_r.s = 'x; exp_r.c = 1'bx; exp_r.z = 1'bx; exp_r.o = 1'bx;
    if (emit && q16.size() > 0) exp_r = q16.pop_front();
    got_r.s = 32'(sum);
    got_r.c = cout;
`ifdef PIPELINED_ADDER_FLAGS_EN
    got_r.z = zero;
    got_r.o = ovf;
`else
    got_r.z = 1'b0;
    got_r.o = 1'b0;
`endif
    if (acc) q16.push_back(ref_model(W, 32'(a), 32'(b), cin, sub));
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                           input logic xs, output res_t got, output int lat, output bit acc0);
    bit acc, emit;
    res_t e;
    a = xa; b = xb; cin = xc; sub = xs;
    in_valid = 1'b1; out_ready = 1'b1;
    step16(acc0, emit, e, got);
    in_valid = 1'b0;
    lat  = 0;
    emit = 1'b0;
    while (!emit && lat < 20) begin
      step16(acc, emit, e, got);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got %h want 0000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
`ifdef PIPELINED_ADDER_FLAGS_EN
    checks++; if ({zero, ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {zero, ovf}); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_carry_wrap();
    res_t g; int lat; bit acc0;
    issue_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, g, lat, acc0);
    checks++; if (acc0 !== 1'b1) begin errors++; $display("FAIL wrap_accept got %b want 1", acc0); end
    checks++; if (lat != S) begin errors++; $display("FAIL wrap_latency got %0d want %0d", lat, S); end
    checks++; if (g.s[15:0] !== 16'h0000) begin errors++; $display("FAIL wrap_sum got %h want 0000", g.s[15:0]); end
    checks++; if (g.c !== 1'b1) begin errors++; $display("FAIL wrap_cout got %b want 1", g.c); end
`ifdef PIPELINED_ADDER_FLAGS_EN
    checks++; if ({g.z, g.o} !== 2'b10) begin errors++; $display("FAIL wrap_flags got %b want 10", {g.z, g.o}); end
`endif
  endtask

  task automatic test_subtract();
    res_t g; int lat; bit acc0;
    issue_one(16'h0005, 16'h0007, 1'b0, 1'b1, g, lat, acc0);
    checks++; if ({g.c, g.s[15:0]} !== {1'b0, 16'hFFFE}) begin errors++; $display("FAIL sub_5_7 got %b/%h want 0/fffe", g.c, g.s[15:0]); end
    issue_one(16'h0005, 16'h0007, 1'b1, 1'b1, g, lat, acc0);
    checks++; if ({g.c, g.s[15:0]} !== {1'b0, 16'hFFFD}) begin errors++; $display("FAIL sub_5_7_borrow got %b/%h want 0/fffd", g.c, g.s[15:0]); end
    issue_one(16'h0007, 16'h0005, 1'b0, 1'b1, g, lat, acc0);
    checks++; if ({g.c, g.s[15:0]} !== {1'b1, 16'h0002}) begin errors++; $display("FAIL sub_7_5 got %b/%h want 1/0002", g.c, g.s[15:0]); end
  endtask

  task automatic test_signed_ovf();
    res_t g; int lat; bit acc0;
    issue_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, g, lat, acc0);
    checks++; if ({g.c, g.s[15:0]} !== {1'b0, 16'h8000}) begin errors++; $display("FAIL ovf_sum got %b/%h want 0/8000", g.c, g.s[15:0]); end
`ifdef PIPELINED_ADDER_FLAGS_EN
    checks++; if ({g.z, g.o} !== 2'b01) begin errors++; $display("FAIL ovf_flags got %b want 01", {g.z, g.o}); end
`endif
  endtask

  task automatic test_back_to_back();
    bit acc, emit; res_t e, g;
    int sent = 0, n = 0, first = -1, last = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
      in_valid = (sent < 8);
      a = 16'($urandom()); b = 16'($urandom());
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      step16(acc, emit, e, g);
      if (acc) sent++;
      if (emit) begin
        checks++; if ({g.c, g.s} !== {e.c, e.s}) begin errors++; $display("FAIL b2b_result got %b/%h want %b/%h", g.c, g.s, e.c, e.s); end
        if (first < 0) first = cyc;
        last = cyc;
        n++;
      end
    end
    in_valid = 1'b0;
    checks++; if (n != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", n); end
    checks++; if (last - first != 7) begin errors++; $display("FAIL b2b_span got %0d want 7", last - first); end
  endtask

  task automatic test_stall();
    bit acc = 1'b1, emit, have = 1'b0; res_t e, g;
    int nacc = 0, n = 0;
    logic [W-1:0] held = '0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (acc) begin
        a = 16'($urandom()); b = 16'($urandom());
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      end
      step16(acc, emit, e, g);
      if (acc) nacc++;
      if (out_valid) begin
        if (!have) begin
          held = sum; have = 1'b1;
        end else begin
          checks++; if (sum !== held) begin errors++; $display("FAIL stall_sum_stable got %h want %h", sum, held); end
        end
      end
    end
    checks++; if (nacc != S) begin errors++; $display("FAIL stall_accepts got %0d want %0d", nacc, S); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && n < S; cyc++) begin
      step16(acc, emit, e, g);
      if (emit) begin
        checks++; if ({g.c, g.s} !== {e.c, e.s}) begin errors++; $display("FAIL stall_drain got %b/%h want %b/%h", g.c, g.s, e.c, e.s); end
        n++;
      end
    end
    checks++; if (n != S) begin errors++; $display("FAIL stall_drain_count got %0d want %0d", n, S); end
  endtask

  task automatic test_reset_midstream();
    bit acc, emit; res_t e, g;
    int stray = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < S; i++) begin
      a = 16'($urandom()); b = 16'($urandom()); cin = 1'b0; sub = 1'b0;
      step16(acc, emit, e, g);
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    checks++; if ({cout, sum} !== 17'h0) begin errors++; $display("FAIL midrst_data got %b/%h want 0/0000", cout, sum); end
    @(negedge clk);
    rst_n = 1'b1;
    q16.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      step16(acc, emit, e, g);
      if (emit) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL midrst_stale got %0d results want 0", stray); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_random(input int idx, input int n);
    res_t q[$];
    res_t e;
    bit acc = 1'b0, emit;
    int sent = 0, got_n = 0, cyc = 0;
    r_in_valid[idx] = 1'b0;
    while (got_n < n && cyc < 3000) begin
      if (acc || !r_in_valid[idx]) begin
        r_in_valid[idx] = (sent < n) && ($urandom_range(0, 3) != 0);
        r_a[idx]   = rand_operand();
        r_b[idx]   = rand_operand();
        r_cin[idx] = 1'($urandom_range(0, 1));
        r_sub[idx] = 1'($urandom_range(0, 1));
      end
      r_out_ready[idx] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      #1;
      acc  = r_in_valid[idx] && r_in_ready[idx];
      emit = r_out_valid[idx] && r_out_ready[idx];
      if (emit) begin
        e.s = 'x; e.c = 1'bx; e.z = 1'bx; e.o = 1'bx;
        if (q.size() > 0) e = q.pop_front();
        checks++;
        if ({r_cout[idx], r_sum[idx]} !== {e.c, e.s}) begin
          errors++; $display("FAIL rand%0d_result got %b/%h want %b/%h", idx, r_cout[idx], r_sum[idx], e.c, e.s);
        end
`ifdef PIPELINED_ADDER_FLAGS_EN
        checks++;
        if ({r_zero[idx], r_ovf[idx]} !== {e.z, e.o}) begin
          errors++; $display("FAIL rand%0d_flags got %b want %b", idx, {r_zero[idx], r_ovf[idx]}, {e.z, e.o});
        end
`endif
        got_n++;
      end
      if (acc) begin
        q.push_back(ref_model(32, r_a[idx], r_b[idx], r_cin[idx], r_sub[idx]));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    r_in_valid[idx]  = 1'b0;
    r_out_ready[idx] = 1'b1;
    checks++; if (got_n != n) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", idx, got_n, n); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      r_in_valid[i] = 1'b0; r_out_ready[i] = 1'b1;
      r_a[i] = '0; r_b[i] = '0; r_cin[i] = 1'b0; r_sub[i] = 1'b0;
    end
    test_reset();
    test_carry_wrap();
    test_subtract();
    test_signed_ovf();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    test_random(0, 60);
    test_random(1, 60);
    test_random(2, 60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
